// File: rtl/brick_wall_engine.sv
// Brick-field engine: multi-hit brick wall storage, 2-stage beam scan to brick graphics,
// one ball hit per frame with write-back, brick counting and FILL/PLAY/CLEAR sequencing.
module brick_wall_engine #(
  parameter int BRICKS_H     = 16,
  parameter int BRICKS_V     = 8,
  parameter int BRICK_W_LOG2 = 4,
  parameter int BRICK_H_LOG2 = 3,
  parameter int LEFT_X       = 8,
  parameter int TOP_Y        = 64,
  parameter int HITS_W       = 2
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic [8:0]                               hpos,
  input  logic [8:0]                               vpos,
  input  logic                                     vsync,
  input  logic                                     ball_gfx,
  input  logic                                     new_level,
  input  logic [HITS_W-1:0]                        level_hits,
  output logic                                     brick_gfx,
  output logic [HITS_W-1:0]                        brick_hits,
  output logic                                     hit,
  output logic                                     incscore,
  output logic [$clog2(BRICKS_H*BRICKS_V+1)-1:0]   bricks_left,
  output logic                                     level_clear,
  output logic                                     busy
);

  localparam int N      = BRICKS_H * BRICKS_V;
  localparam int IDX_W  = (N > 1) ? $clog2(N) : 1;
  localparam int CNT_W  = $clog2(N + 1);
  localparam int WALL_R = LEFT_X + (BRICKS_H << BRICK_W_LOG2);
  localparam int WALL_B = TOP_Y + (BRICKS_V << BRICK_H_LOG2);
  localparam logic [8:0] X_MASK = 9'((1 << BRICK_W_LOG2) - 1);
  localparam logic [8:0] Y_MASK = 9'((1 << BRICK_H_LOG2) - 1);

  typedef enum logic [1:0] {S_FILL, S_PLAY, S_CLEAR} state_t;

  // A refill strength of zero would leave the wall empty, so it loads one instead.
  function automatic logic [HITS_W-1:0] fill_strength(input logic [HITS_W-1:0] h);
    return (h == '0) ? HITS_W'(1) : h;
  endfunction

  function automatic logic [HITS_W-1:0] strength_dec(input logic [HITS_W-1:0] h);
    return (h == '0) ? '0 : h - HITS_W'(1);
  endfunction

  logic [HITS_W-1:0] mem [N];

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  fill_cnt_q, fill_cnt_d;
  logic [CNT_W-1:0]  bricks_left_q, bricks_left_d;
  logic              busy_q, busy_d;
  logic              hit_q, hit_d;
  logic              incscore_q, incscore_d;
  logic              level_clear_q, level_clear_d;
  logic              hit_lock_q, hit_lock_d;
  logic              vsync_prev_q;

  logic              vld_p1_q, vld_p1_d;
  logic              ball_p1_q;
  logic              mortar_p1_q, mortar_p1_d;
  logic [IDX_W-1:0]  idx_p1_q, idx_p1_d;

  logic              brick_gfx_q, brick_gfx_d;
  logic [HITS_W-1:0] brick_hits_q, brick_hits_d;
  logic              ball_p2_q;
  logic [IDX_W-1:0]  idx_p2_q;

  logic              mem_we;
  logic [IDX_W-1:0]  mem_waddr;
  logic [HITS_W-1:0] mem_wdata;
  logic              collide, destroy, last_brick;

  logic              in_wall;
  logic [8:0]        dx, dy, col, row;
  logic [HITS_W-1:0] rd_hits;

  // Stage 1: beam position to brick index, in-wall and mortar flags
  always_comb begin
    in_wall = ({1'b0, hpos} >= 10'(LEFT_X)) && ({1'b0, hpos} < 10'(WALL_R)) &&
              ({1'b0, vpos} >= 10'(TOP_Y))  && ({1'b0, vpos} < 10'(WALL_B));
    dx = hpos - 9'(LEFT_X);
    dy = vpos - 9'(TOP_Y);
    col = dx >> BRICK_W_LOG2;
    row = dy >> BRICK_H_LOG2;
    idx_p1_d    = in_wall ? IDX_W'(32'(row) * BRICKS_H + 32'(col)) : '0;
    mortar_p1_d = ((dx & X_MASK) == 9'd0) || ((dy & Y_MASK) == 9'd0);
    vld_p1_d    = in_wall && (state_q == S_PLAY);
  end

  // Stage 2: array read into brick graphics / strength
  always_comb begin
    rd_hits = mem[idx_p1_q];
    brick_hits_d = '0;
    brick_gfx_d  = 1'b0;
    if (vld_p1_q && state_q == S_PLAY) begin
      brick_hits_d = rd_hits;
      brick_gfx_d  = !mortar_p1_q && (rd_hits != '0);
    end
  end

  // Stage 3: collision, write-back and FSM sequencing
  always_comb begin
    collide    = (state_q == S_PLAY) && brick_gfx_q && ball_p2_q && !hit_lock_q && !new_level;
    destroy    = collide && (brick_hits_q == HITS_W'(1));
    last_brick = destroy && (bricks_left_q == CNT_W'(1));

    state_d       = state_q;
    fill_cnt_d    = fill_cnt_q;
    bricks_left_d = bricks_left_q;
    mem_we        = 1'b0;
    mem_waddr     = idx_p2_q;
    mem_wdata     = strength_dec(brick_hits_q);

    if (new_level) begin
      state_d       = S_FILL;
      fill_cnt_d    = '0;
      bricks_left_d = '0;
    end else begin
      case (state_q)
        S_FILL: begin
          mem_we    = 1'b1;
          mem_waddr = fill_cnt_q;
          mem_wdata = fill_strength(level_hits);
          if (fill_cnt_q == IDX_W'(N - 1)) begin
            state_d       = S_PLAY;
            fill_cnt_d    = '0;
            bricks_left_d = CNT_W'(N);
          end else begin
            fill_cnt_d = fill_cnt_q + IDX_W'(1);
          end
        end
        S_PLAY: begin
          if (collide) mem_we = 1'b1;
          if (destroy) bricks_left_d = bricks_left_q - CNT_W'(1);
          if (last_brick) state_d = S_CLEAR;
        end
        default: ;
      endcase
    end

    busy_d        = (state_d == S_FILL);
    hit_d         = collide;
    incscore_d    = destroy;
    level_clear_d = last_brick;

    // The frame's lock releases after vsync rises; a hit on that same clk re-arms it.
    hit_lock_d = hit_lock_q;
    if (vsync && !vsync_prev_q) hit_lock_d = 1'b0;
    if (collide) hit_lock_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_FILL;
      fill_cnt_q    <= '0;
      bricks_left_q <= '0;
      busy_q        <= 1'b1;
      hit_q         <= 1'b0;
      incscore_q    <= 1'b0;
      level_clear_q <= 1'b0;
      hit_lock_q    <= 1'b0;
      vsync_prev_q  <= 1'b0;
      vld_p1_q      <= 1'b0;
      ball_p1_q     <= 1'b0;
      ball_p2_q     <= 1'b0;
      brick_gfx_q   <= 1'b0;
      brick_hits_q  <= '0;
    end else begin
      state_q       <= state_d;
      fill_cnt_q    <= fill_cnt_d;
      bricks_left_q <= bricks_left_d;
      busy_q        <= busy_d;
      hit_q         <= hit_d;
      incscore_q    <= incscore_d;
      level_clear_q <= level_clear_d;
      hit_lock_q    <= hit_lock_d;
      vsync_prev_q  <= vsync;
      vld_p1_q      <= vld_p1_d;
      ball_p1_q     <= ball_gfx;
      ball_p2_q     <= ball_p1_q;
      brick_gfx_q   <= brick_gfx_d;
      brick_hits_q  <= brick_hits_d;
    end
  end

  always_ff @(posedge clk) begin
    idx_p1_q    <= idx_p1_d;
    mortar_p1_q <= mortar_p1_d;
    idx_p2_q    <= idx_p1_q;
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  assign brick_gfx   = brick_gfx_q;
  assign brick_hits  = brick_hits_q;
  assign hit         = hit_q;
  assign incscore    = incscore_q;
  assign bricks_left = bricks_left_q;
  assign level_clear = level_clear_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_brick_wall_engine.sv
// Directed bench for brick_wall_engine: a default 16x8 wall and a 2x1 wall share stimulus.
module tb_brick_wall_engine;

  logic       clk = 1'b0;
  logic       reset;
  logic [8:0] hpos, vpos;
  logic       vsync, ball_gfx, new_level;
  logic [1:0] level_hits;

  logic       b_gfx, b_hit, b_inc, b_lc, b_busy;
  logic [1:0] b_hits;
  logic [7:0] b_bl;
  logic       s_gfx, s_hit, s_inc, s_lc, s_busy;
  logic [1:0] s_hits;
  logic [1:0] s_bl;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  brick_wall_engine dut_big (
    .clk(clk), .reset(reset), .hpos(hpos), .vpos(vpos), .vsync(vsync),
    .ball_gfx(ball_gfx), .new_level(new_level), .level_hits(level_hits),
    .brick_gfx(b_gfx), .brick_hits(b_hits), .hit(b_hit), .incscore(b_inc),
    .bricks_left(b_bl), .level_clear(b_lc), .busy(b_busy)
  );

  brick_wall_engine #(.BRICKS_H(2), .BRICKS_V(1)) dut_small (
    .clk(clk), .reset(reset), .hpos(hpos), .vpos(vpos), .vsync(vsync),
    .ball_gfx(ball_gfx), .new_level(new_level), .level_hits(level_hits),
    .brick_gfx(s_gfx), .brick_hits(s_hits), .hit(s_hit), .incscore(s_inc),
    .bricks_left(s_bl), .level_clear(s_lc), .busy(s_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pix(input int x, input int y, input logic b);
    hpos = 9'(x);
    vpos = 9'(y);
    ball_gfx = b;
  endtask

  task automatic frame();
    vsync = 1'b1;
    step();
    vsync = 1'b0;
    step();
  endtask

  // Present a beam pixel and return with outputs for it visible (2 clks later).
  task automatic probe(input int x, input int y);
    pix(x, y, 1'b0);
    step();
    pix(0, 0, 1'b0);
    step();
  endtask

  // Ball on one pixel; returns on the clk where the hit pulse belongs (3 clks later).
  task automatic strike(input int x, input int y);
    pix(x, y, 1'b1);
    step();
    pix(0, 0, 1'b0);
    step();
    step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n, nh, nhs, ni;
    reset = 1'b1;
    vsync = 1'b0;
    new_level = 1'b0;
    level_hits = 2'd2;
    pix(0, 0, 1'b0);
    step();
    step();

    chk("rst_gfx",   32'(b_gfx),  0);
    chk("rst_hits",  32'(b_hits), 0);
    chk("rst_hit",   32'(b_hit),  0);
    chk("rst_inc",   32'(b_inc),  0);
    chk("rst_lc",    32'(b_lc),   0);
    chk("rst_left",  32'(b_bl),   0);
    chk("rst_busy",  32'(b_busy), 1);

    // Refill from reset release
    reset = 1'b0;
    n = 0;
    while (b_busy && n < 400) begin
      step();
      n++;
    end
    chk("fill_len",   32'(n),    128);
    chk("fill_left",  32'(b_bl), 128);
    chk("s_fill_left", 32'(s_bl), 2);
    chk("s_fill_busy", 32'(s_busy), 0);

    for (int i = 0; i <= 128; i++) begin
      if (i < 128) pix(8 + (i % 16) * 16 + 8, 64 + (i / 16) * 8 + 4, 1'b0);
      else pix(0, 0, 1'b0);
      step();
      if (i >= 1) begin
        chk($sformatf("wall_hits_%0d", i - 1), 32'(b_hits), 2);
        chk($sformatf("wall_gfx_%0d", i - 1),  32'(b_gfx),  1);
      end
    end

    // Scan alignment, mortar and out-of-wall
    probe(9, 65);
    chk("scan_gfx", 32'(b_gfx), 1);
    probe(24, 65);
    chk("mortar_gfx",  32'(b_gfx),  0);
    chk("mortar_hits", 32'(b_hits), 2);
    probe(9, 64);
    chk("mortar_y_gfx", 32'(b_gfx), 0);
    probe(7, 65);
    chk("left_out_gfx",  32'(b_gfx),  0);
    chk("left_out_hits", 32'(b_hits), 0);
    probe(9, 128);
    chk("bot_out_hits", 32'(b_hits), 0);
    probe(264, 65);
    chk("right_out_hits", 32'(b_hits), 0);

    // Two-hit brick 0
    frame();
    strike(9, 65);
    chk("f1_hit",  32'(b_hit), 1);
    chk("f1_inc",  32'(b_inc), 0);
    chk("f1_lc",   32'(b_lc),  0);
    chk("f1_left", 32'(b_bl),  128);
    step();
    chk("f1_hit_end", 32'(b_hit), 0);
    probe(12, 66);
    chk("f1_str", 32'(b_hits), 1);
    chk("f1_gfx", 32'(b_gfx),  1);
    frame();
    strike(9, 65);
    chk("f2_hit",    32'(b_hit), 1);
    chk("f2_inc",    32'(b_inc), 1);
    chk("f2_left",   32'(b_bl),  127);
    chk("s_f2_inc",  32'(s_inc), 1);
    chk("s_f2_left", 32'(s_bl),  1);
    chk("s_f2_lc",   32'(s_lc),  0);
    step();
    chk("f2_inc_end", 32'(b_inc), 0);
    frame();
    probe(12, 66);
    chk("f3_gfx",  32'(b_gfx),  0);
    chk("f3_hits", 32'(b_hits), 0);

    // One hit per frame: ball swept across bricks 1 and 2
    frame();
    nh = 0; nhs = 0; ni = 0;
    for (int x = 25; x < 56; x++) begin
      pix(x, 65, 1'b1);
      step();
      nh += int'(b_hit); nhs += int'(s_hit); ni += int'(b_inc);
    end
    pix(0, 0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step();
      nh += int'(b_hit); nhs += int'(s_hit); ni += int'(b_inc);
    end
    chk("sweep_hits",   32'(nh),  1);
    chk("s_sweep_hits", 32'(nhs), 1);
    chk("sweep_inc",    32'(ni),  0);
    probe(30, 66);
    chk("brick1_str",   32'(b_hits), 1);
    chk("s_brick1_str", 32'(s_hits), 1);
    probe(45, 66);
    chk("brick2_str", 32'(b_hits), 2);
    chk("sweep_left", 32'(b_bl),   127);

    // new_level wins over a simultaneous collision on brick 3
    frame();
    level_hits = 2'd1;
    pix(57, 65, 1'b1);
    step();
    pix(0, 0, 1'b0);
    step();
    new_level = 1'b1;
    step();
    new_level = 1'b0;
    chk("prio_hit",  32'(b_hit),  0);
    chk("prio_inc",  32'(b_inc),  0);
    chk("prio_busy", 32'(b_busy), 1);
    n = 0;
    while (b_busy && n < 400) begin
      step();
      n++;
    end
    chk("prio_fill_len", 32'(n),    128);
    chk("prio_left",     32'(b_bl), 128);
    chk("s_prio_left",   32'(s_bl), 2);

    // Level clear on the 2x1 wall
    frame();
    strike(9, 65);
    chk("s_lc1_hit",  32'(s_hit), 1);
    chk("s_lc1_inc",  32'(s_inc), 1);
    chk("s_lc1_lc",   32'(s_lc),  0);
    chk("s_lc1_left", 32'(s_bl),  1);
    chk("lc1_left",   32'(b_bl),  127);
    step();
    frame();
    strike(25, 65);
    chk("s_lc2_hit",  32'(s_hit), 1);
    chk("s_lc2_inc",  32'(s_inc), 1);
    chk("s_lc2_lc",   32'(s_lc),  1);
    chk("s_lc2_left", 32'(s_bl),  0);
    chk("lc2_lc",     32'(b_lc),  0);
    chk("lc2_left",   32'(b_bl),  126);
    step();
    chk("s_lc_end",  32'(s_lc),   0);
    chk("s_lc_busy", 32'(s_busy), 0);
    probe(30, 66);
    chk("s_clear_gfx",  32'(s_gfx),  0);
    chk("s_clear_hits", 32'(s_hits), 0);
    new_level = 1'b1;
    step();
    new_level = 1'b0;
    chk("s_refill_busy0", 32'(s_busy), 1);
    step();
    chk("s_refill_busy1", 32'(s_busy), 1);
    step();
    chk("s_refill_busy2", 32'(s_busy), 0);
    chk("s_refill_left",  32'(s_bl),   2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
